miriscv_data_mem: RTL

Word-organised data memory slave that terminates the core's data memory protocol (req/we/be/addr/wdata -> gnt/rvalid/rdata). It sits directly downstream of the load/store unit. It accepts one transaction at a time, applies byte-enabled writes, and returns read data after a programmable latency. Out-of-range accesses are flagged with an error pulse.

---
 rtl/miriscv_data_mem.sv | 132 +++++++++++++
 1 files changed

// File: rtl/miriscv_data_mem.sv
// Word-organised data memory slave for the core's data port: one transaction
// at a time, byte-enabled writes, read/write response after LATENCY cycles.
//
// state | meaning
// IDLE  | ready; a request is granted combinationally in this cycle
// WAIT  | transaction latched, counting down to the response cycle
// RESP  | rvalid pulse; rdata/err describe the latched transaction
module miriscv_data_mem #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned LATENCY     = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
   // 33 bits so that the span of a very large memory cannot wrap to zero
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam state_t GRANT_NEXT = (LATENCY == 1) ? ST_RESP : ST_WAIT;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             in_range_q, in_range_d;

   logic [31:0]      mem_q [DEPTH_WORDS];

   logic [31:0]      addr_offset;
   logic             addr_in_range;
   logic [IDX_W-1:0] addr_idx;
   logic             mem_wr_en;
   logic             resp;

   // Addresses below BASE_ADDR are rejected explicitly; the subtraction
   // alone would wrap them into a large in-range-looking offset.
   assign addr_offset   = data_addr_i - BASE_ADDR;
   assign addr_in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, addr_offset} < SPAN_BYTES);
   assign addr_idx      = addr_offset[IDX_W+1:2];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      idx_d      = idx_q;
      in_range_d = in_range_q;
      data_gnt_o = 1'b0;
      mem_wr_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (data_req_i) begin
               data_gnt_o = 1'b1;
               we_d       = data_we_i;
               idx_d      = addr_idx;
               in_range_d = addr_in_range;
               mem_wr_en  = data_we_i & addr_in_range;
               cnt_d      = CNT_INIT;
               state_d    = GRANT_NEXT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         idx_q      <= idx_d;
         in_range_q <= in_range_d;
      end
   end

   // Storage is deliberately not reset; a write performed on its grant edge
   // survives a later reset of the control path.
   always_ff @(posedge clk_i) begin
      if (mem_wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (data_be_i[k]) begin
               mem_q[addr_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
            end
         end
      end
   end

   // Read data comes from the array during RESP so writes completed before
   // the response cycle are visible.
   assign resp          = (state_q == ST_RESP);
   assign data_rvalid_o = resp;
   assign data_err_o    = resp & ~in_range_q;
   assign data_rdata_o  = (resp & ~we_q & in_range_q) ? mem_q[idx_q] : 32'h0;

endmodule
